// File: rtl/alu_issue_stage.sv
// alu_issue_stage: MIPS32 decode-and-issue stage feeding the ALU.
// Decodes a raw instruction into a 4-bit ALU control code and A/B operands,
// then presents the bundle from a registered main output register backed by
// a single skid register, so the upstream ready can be fully registered.
//
// ALU control code: [3:2] unit select, [1:0] sub-op
//   0000 SLL   0010 SRL   0011 SRA        (shifter, shifts A by B[4:0])
//   0110 SLT
//   1000 ADD   1010 SUB                   (bit 1 selects subtract)
//   1100 AND   1101 OR    1110 XOR  1111 NOR
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_flush,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [3:0]  o_alu_control,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [4:0]  o_dest,
  output logic        o_ovf_trap,
  output logic        o_illegal
);

  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b0010;
  localparam logic [3:0] ALU_SRA = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b1101;
  localparam logic [3:0] ALU_XOR = 4'b1110;
  localparam logic [3:0] ALU_NOR = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        ovf;
    logic        ill;
  } bundle_t;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;
  bundle_t     w_dec;
  logic        w_accept;

  bundle_t     r_main;
  logic        r_main_valid;
  bundle_t     r_skid;
  logic        r_skid_valid;
  logic        r_in_ready;

  assign w_opcode   = i_instr[31:26];
  assign w_rt       = i_instr[20:16];
  assign w_rd       = i_instr[15:11];
  assign w_shamt    = i_instr[10:6];
  assign w_funct    = i_instr[5:0];
  assign w_imm      = i_instr[15:0];
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
  assign w_imm_zext = {16'h0000, w_imm};

  // Decode the offered instruction; anything unrecognised falls through to the
  // illegal bundle (ADD of rs/rt, no writeback, no trap) which is still issued.
  always_comb begin
    w_dec.ctl  = ALU_ADD;
    w_dec.a    = i_rs_data;
    w_dec.b    = i_rt_data;
    w_dec.dest = 5'd0;
    w_dec.ovf  = 1'b0;
    w_dec.ill  = 1'b1;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_SLL:  begin w_dec.ctl = ALU_SLL; w_dec.a = i_rt_data; w_dec.b = {27'd0, w_shamt}; w_dec.ill = 1'b0; end
          FN_SRL:  begin w_dec.ctl = ALU_SRL; w_dec.a = i_rt_data; w_dec.b = {27'd0, w_shamt}; w_dec.ill = 1'b0; end
          FN_SRA:  begin w_dec.ctl = ALU_SRA; w_dec.a = i_rt_data; w_dec.b = {27'd0, w_shamt}; w_dec.ill = 1'b0; end
          FN_SLLV: begin w_dec.ctl = ALU_SLL; w_dec.a = i_rt_data; w_dec.b = i_rs_data; w_dec.ill = 1'b0; end
          FN_SRLV: begin w_dec.ctl = ALU_SRL; w_dec.a = i_rt_data; w_dec.b = i_rs_data; w_dec.ill = 1'b0; end
          FN_SRAV: begin w_dec.ctl = ALU_SRA; w_dec.a = i_rt_data; w_dec.b = i_rs_data; w_dec.ill = 1'b0; end
          FN_ADD:  begin w_dec.ctl = ALU_ADD; w_dec.ovf = 1'b1; w_dec.ill = 1'b0; end
          FN_ADDU: begin w_dec.ctl = ALU_ADD; w_dec.ill = 1'b0; end
          FN_SUB:  begin w_dec.ctl = ALU_SUB; w_dec.ovf = 1'b1; w_dec.ill = 1'b0; end
          FN_SUBU: begin w_dec.ctl = ALU_SUB; w_dec.ill = 1'b0; end
          FN_AND:  begin w_dec.ctl = ALU_AND; w_dec.ill = 1'b0; end
          FN_OR:   begin w_dec.ctl = ALU_OR;  w_dec.ill = 1'b0; end
          FN_XOR:  begin w_dec.ctl = ALU_XOR; w_dec.ill = 1'b0; end
          FN_NOR:  begin w_dec.ctl = ALU_NOR; w_dec.ill = 1'b0; end
          FN_SLT:  begin w_dec.ctl = ALU_SLT; w_dec.ill = 1'b0; end
          default: ;
        endcase
        // Only a recognised funct writes back to rd.
        if (!w_dec.ill) w_dec.dest = w_rd;
      end
      OP_ADDI: begin
        w_dec.b = w_imm_sext; w_dec.dest = w_rt; w_dec.ovf = 1'b1; w_dec.ill = 1'b0;
      end
      OP_ADDIU, OP_LW: begin
        w_dec.b = w_imm_sext; w_dec.dest = w_rt; w_dec.ill = 1'b0;
      end
      OP_SLTI: begin
        w_dec.ctl = ALU_SLT; w_dec.b = w_imm_sext; w_dec.dest = w_rt; w_dec.ill = 1'b0;
      end
      OP_ANDI: begin
        w_dec.ctl = ALU_AND; w_dec.b = w_imm_zext; w_dec.dest = w_rt; w_dec.ill = 1'b0;
      end
      OP_ORI: begin
        w_dec.ctl = ALU_OR; w_dec.b = w_imm_zext; w_dec.dest = w_rt; w_dec.ill = 1'b0;
      end
      OP_XORI: begin
        w_dec.ctl = ALU_XOR; w_dec.b = w_imm_zext; w_dec.dest = w_rt; w_dec.ill = 1'b0;
      end
      OP_SW: begin
        // Address generation only; stores never write the register file.
        w_dec.b = w_imm_sext; w_dec.ill = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        // Compare by subtraction; EX resolves the branch on ZF.
        w_dec.ctl = ALU_SUB; w_dec.ill = 1'b0;
      end
      OP_LUI: begin
        // Built as a shift so no dedicated upper-immediate path is needed.
        w_dec.ctl = ALU_SLL; w_dec.a = w_imm_zext; w_dec.b = 32'd16;
        w_dec.dest = w_rt; w_dec.ill = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_accept = i_in_valid && r_in_ready && !i_flush;

  // Main/skid buffer. in_ready only depends on skid occupancy, so an accept
  // can never coincide with a full skid, and the skid-to-main move never races
  // a new bundle for the main slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_main_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_main_valid || i_out_ready) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_accept) begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_main_valid;
  assign o_alu_control = r_main.ctl;
  assign o_alu_a       = r_main.a;
  assign o_alu_b       = r_main.b;
  assign o_dest        = r_main.dest;
  assign o_ovf_trap    = r_main.ovf;
  assign o_illegal     = r_main.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage. Outputs are sampled 1 time unit
// after the rising edge; inputs are changed right after that sample.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  dest;
  logic        ovf_trap;
  logic        illegal;

  int n_pass;
  int n_total;

  // {out_valid, alu_control, alu_a, alu_b, dest, ovf_trap, illegal}
  logic [75:0] obs;
  logic [75:0] exp;
  assign obs = {out_valid, alu_control, alu_a, alu_b, dest, ovf_trap, illegal};

  alu_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_instr       (instr),
    .i_rs_data     (rs_data),
    .i_rt_data     (rt_data),
    .i_flush       (flush),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_alu_control (alu_control),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .o_dest        (dest),
    .o_ovf_trap    (ovf_trap),
    .o_illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
    in_valid = 1'b1;
    instr    = ins;
    rs_data  = rsd;
    rt_data  = rtd;
  endtask

  task automatic idle_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    #13;
    n_total++;
    if (obs !== 76'd0) $display("FAIL reset_outputs got=%h exp=%h", obs, 76'd0);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    offer(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    step();
    in_valid = 1'b0;
    exp = {1'b1, 4'b1000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL add got=%h exp=%h", obs, exp);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL add_drained got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_immediates();
    out_ready = 1'b1;
    offer(itype(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd10, 32'd99);
    step();
    exp = {1'b1, 4'b1000, 32'd10, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL addi got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(itype(6'h0F, 5'd0, 5'd5, 16'h1234), 32'hDEAD_BEEF, 32'd0);
    step();
    exp = {1'b1, 4'b0000, 32'h0000_1234, 32'd16, 5'd5, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL lui got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(itype(6'h0D, 5'd2, 5'd6, 16'h8000), 32'h0000_0001, 32'd0);
    step();
    exp = {1'b1, 4'b1101, 32'h0000_0001, 32'h0000_8000, 5'd6, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL ori got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(rtype(5'd0, 5'd8, 5'd7, 5'd4, 6'h00), 32'h5555_5555, 32'd1);
    step();
    exp = {1'b1, 4'b0000, 32'd1, 32'd4, 5'd7, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL sll got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(rtype(5'd3, 5'd4, 5'd9, 5'd0, 6'h07), 32'd3, 32'h8000_0000);
    step();
    exp = {1'b1, 4'b0011, 32'h8000_0000, 32'd3, 5'd9, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL srav got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(itype(6'h04, 5'd1, 5'd3, 16'h0010), 32'd6, 32'd6);
    step();
    exp = {1'b1, 4'b1010, 32'd6, 32'd6, 5'd0, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL beq got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(itype(6'h2B, 5'd1, 5'd3, 16'hFFFC), 32'h100, 32'd77);
    step();
    exp = {1'b1, 4'b1000, 32'h100, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL sw got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(itype(6'h0A, 5'd1, 5'd12, 16'h8001), 32'd0, 32'd0);
    step();
    exp = {1'b1, 4'b0110, 32'd0, 32'hFFFF_8001, 5'd12, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL slti got=%h exp=%h", obs, exp);
    else n_pass++;
    // Simultaneous accept and drain into a full main: skid must stay empty.
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL stream_in_ready got=%b exp=1", in_ready);
    else n_pass++;
    idle_drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    offer(rtype(5'd1, 5'd2, 5'd1, 5'd0, 6'h21), 32'd100, 32'd1);
    step();
    n_total++;
    if ({out_valid, alu_a, dest, in_ready} !== {1'b1, 32'd100, 5'd1, 1'b1})
      $display("FAIL bp_first got=%b/%0d/%0d/%b exp=1/100/1/1", out_valid, alu_a, dest, in_ready);
    else n_pass++;
    offer(rtype(5'd1, 5'd2, 5'd2, 5'd0, 6'h21), 32'd200, 32'd2);
    step();
    n_total++;
    if ({out_valid, alu_a, dest, in_ready} !== {1'b1, 32'd100, 5'd1, 1'b0})
      $display("FAIL bp_second got=%b/%0d/%0d/%b exp=1/100/1/0", out_valid, alu_a, dest, in_ready);
    else n_pass++;
    offer(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd300, 32'd3);
    step();
    n_total++;
    if ({out_valid, alu_a, dest, in_ready} !== {1'b1, 32'd100, 5'd1, 1'b0})
      $display("FAIL bp_third_held got=%b/%0d/%0d/%b exp=1/100/1/0", out_valid, alu_a, dest, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_total++;
    if ({out_valid, alu_a, dest, in_ready} !== {1'b1, 32'd200, 5'd2, 1'b1})
      $display("FAIL bp_recover got=%b/%0d/%0d/%b exp=1/200/2/1", out_valid, alu_a, dest, in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, alu_a, dest, in_ready} !== {1'b1, 32'd300, 5'd3, 1'b1})
      $display("FAIL bp_third_out got=%b/%0d/%0d/%b exp=1/300/3/1", out_valid, alu_a, dest, in_ready);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h25), 32'd11, 32'd0);
    step();
    offer(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h25), 32'd22, 32'd0);
    step();
    n_total++;
    if ({out_valid, in_ready} !== 2'b10) $display("FAIL flush_setup got=%b%b exp=10", out_valid, in_ready);
    else n_pass++;
    offer(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h25), 32'd33, 32'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_clear got=%b%b exp=01", out_valid, in_ready);
    else n_pass++;
    step();
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_leak got=%b exp=0", out_valid);
    else n_pass++;
    // Flush while main holds one and in_ready is high: the offered bundle is dropped.
    out_ready = 1'b0;
    offer(rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h25), 32'd44, 32'd0);
    step();
    offer(rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'h25), 32'd55, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_total++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_drop_offer got=%b%b exp=01", out_valid, in_ready);
    else n_pass++;
    offer(rtype(5'd1, 5'd2, 5'd15, 5'd0, 6'h25), 32'd66, 32'd0);
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, alu_a, dest} !== {1'b1, 32'd66, 5'd15})
      $display("FAIL flush_next got=%b/%0d/%0d exp=1/66/15", out_valid, alu_a, dest);
    else n_pass++;
    step();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    offer(itype(6'h3F, 5'd1, 5'd5, 16'h0123), 32'd9, 32'd8);
    step();
    exp = {1'b1, 4'b1000, 32'd9, 32'd8, 5'd0, 1'b0, 1'b1};
    n_total++;
    if (obs !== exp) $display("FAIL illegal_op got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'd4, 32'd5);
    step();
    exp = {1'b1, 4'b1000, 32'd4, 32'd5, 5'd0, 1'b0, 1'b1};
    n_total++;
    if (obs !== exp) $display("FAIL illegal_funct got=%h exp=%h", obs, exp);
    else n_pass++;
    offer(rtype(5'd1, 5'd2, 5'd2, 5'd0, 6'h22), 32'd20, 32'd3);
    step();
    in_valid = 1'b0;
    exp = {1'b1, 4'b1010, 32'd20, 32'd3, 5'd2, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL legal_after got=%h exp=%h", obs, exp);
    else n_pass++;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    offer(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h24), 32'd7, 32'd7);
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({obs, in_ready} !== {76'd0, 1'b1}) $display("FAIL async_reset got=%h/%b exp=0/1", obs, in_ready);
    else n_pass++;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    n_total++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL reset_no_survivor got=%b%b exp=01", out_valid, in_ready);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_add();
    test_immediates();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that produces the ALU's command interface. It accepts a raw MIPS32 instruction word plus register-file read data over a valid/ready handshake. It decodes the 4-bit ALU control code, builds the A/B operands, and presents them from a registered ID/EX output with a 2-entry skid buffer. The ALU and its OF/ZF flags sit directly downstream.

## Interface
- No parameters; all widths are fixed by the MIPS32 datapath.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instr/rs_data/rt_data are valid this cycle.
- in_ready  out  1  stage can accept an input this cycle; registered.
- instr  in  32  raw instruction word.
- rs_data  in  32  register-file value of instr[25:21].
- rt_data  in  32  register-file value of instr[20:16].
- flush  in  1  synchronous kill of all held and incoming entries.
- out_valid  out  1  issue bundle valid.
- out_ready  in  1  ALU/EX stage consumes the bundle.
- alu_control  out  4  [3:2] unit select, [1:0] sub-op.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- dest  out  5  writeback register index; 0 means no writeback.
- ovf_trap  out  1  EX must trap on ALU OF.
- illegal  out  1  opcode/funct not supported.

## Operation
- ALU control encoding:
  - Shifter (select 00): SLL 0000, SRL 0010, SRA 0011. The ALU shifts A by B[4:0].
  - SLT (select 01): 0110.
  - Adder (select 10): ADD 1000, SUB 1010. Bit 1 selects subtract.
  - Logic (select 11): AND 1100, OR 1101, XOR 1110, NOR 1111.
- Opcode 0x00 (R-type), dispatched on funct. Default dest = rd.
  - Immediate shifts: SLL 0x00, SRL 0x02, SRA 0x03. A = rt_data, B = {27'b0, shamt}.
  - Variable shifts: SLLV 0x04, SRLV 0x06, SRAV 0x07. A = rt_data, B = rs_data.
  - ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A. A = rs_data, B = rt_data.
  - ovf_trap = 1 only for ADD and SUB.
- I-type. Default A = rs_data, dest = rt.
  - ADDI 0x08: ADD, sign-extended immediate, ovf_trap = 1.
  - ADDIU 0x09: ADD, sign-extended immediate.
  - SLTI 0x0A: SLT, sign-extended immediate.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: zero-extended immediate.
  - LW 0x23: ADD, sign-extended immediate.
  - SW 0x2B: ADD, sign-extended immediate, dest = 0.
  - BEQ 0x04, BNE 0x05: SUB, B = rt_data, dest = 0. Branch resolves on ZF.
  - LUI 0x0F: SLL, A = {16'b0, imm}, B = 16.
- Any other opcode or funct:
  - illegal = 1, alu_control = 1000, A = rs_data, B = rt_data, dest = 0, ovf_trap = 0.
  - The bundle is still issued.
- Buffering uses a main output register and one skid register.
  - Accept occurs when in_valid && in_ready && !flush.
  - The accepted bundle goes to main if main is empty or draining (out_ready high). Otherwise it goes to skid.
  - When main drains while skid is full, skid moves to main.
  - in_ready = !skid_valid, registered.
- Order is strictly FIFO. No bundle is duplicated or dropped except by flush.

## Timing
- Reset values:
  - out_valid = 0, in_ready = 1.
  - alu_control = 0, alu_a = 0, alu_b = 0, dest = 0, ovf_trap = 0, illegal = 0.
  - Skid register empty.
- Latency: an input accepted at edge N is on the outputs after edge N, provided main was empty or draining.
- Throughput: 1 bundle/cycle while out_ready is held high.
- Back-pressure:
  - out_ready low with main full: the next accept fills skid, and in_ready drops after that edge.
  - A third input is never taken.
- Output stability: while out_valid && !out_ready, all outputs hold stable.
- Recovery: the first out_ready-high cycle with skid full drains main; skid moves to main, and in_ready rises one cycle later.
- Simultaneous accept and drain with main full and skid empty: the new bundle goes to main and skid stays empty.
- Flush:
  - Clears main and skid valid at the next edge.
  - The input offered in the flush cycle is dropped.
  - in_ready = 1 and out_valid = 0 after the edge.
  - Flush overrides out_ready.
- rst_n asserted mid-transfer: all state clears immediately and no partial bundle survives.

## Test plan
- ADD (rs_data = 5, rt_data = 7, rd = 3) with out_ready = 1 -> one cycle later: alu_control = 1000, A = 5, B = 7, dest = 3, ovf_trap = 1.
- ADDI with imm 0xFFFF, then LUI with imm 0x1234 -> first: B = 0xFFFFFFFF, dest = rt. Second: alu_control = 0000, A = 0x00001234, B = 16.
- ORI with imm 0x8000, then SLL with shamt = 4 (rt_data = 1) -> first: B = 0x00008000. Second: A = 1, B = 4, alu_control = 0000.
- Stream 3 back-to-back inputs while out_ready = 0 -> in_ready falls after the 2nd accept. Raise out_ready -> all 3 emerge in order; in_ready = 1 again.
- Two entries held, then assert flush for one cycle with in_valid = 1 -> out_valid = 0 and in_ready = 1 next cycle. Nothing from before or during the flush appears later.
- Opcode 0x3F, then R-type funct 0x3F -> illegal = 1, dest = 0, alu_control = 1000 for both. A legal instruction that follows issues with illegal = 0.
